// File: rtl/mat_mult_pkg.sv
// Shared types and default sizing for the matrix-multiply operand feeder.
package mat_mult_pkg;

    // Feeder sequencing: collect a tile, stream it, then let the skew drain.
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } feeder_state_e;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_K     = 4;

    // Counter width able to hold values up to max(k, n) inclusive.
    function automatic int unsigned cnt_width(input int unsigned k, input int unsigned n);
        int unsigned m;
        m = (k > n) ? k : n;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane delay of an operand and its valid flag by DELAY register stages.
// DELAY=0 is a straight wire; the caller supplies an already-registered input.
module skew_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DELAY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    if (DELAY == 0) begin : g_pass
        assign out_data  = in_data;
        assign out_valid = in_valid;
    end else begin : g_shift
        logic [WIDTH-1:0] data_q  [DELAY];
        logic [DELAY-1:0] valid_q;

        for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
            logic [WIDTH-1:0] data_d;
            logic             valid_d;

            // Select the stage input: module input for the first stage, previous stage otherwise.
            if (gi == 0) begin : g_head
                always_comb begin
                    data_d  = in_data;
                    valid_d = in_valid;
                end
            end else begin : g_body
                always_comb begin
                    data_d  = data_q[gi-1];
                    valid_d = valid_q[gi-1];
                end
            end

            // Stage register; reset empties the line so no stale operand emerges.
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q[gi]  <= '0;
                    valid_q[gi] <= 1'b0;
                end else begin
                    data_q[gi]  <= data_d;
                    valid_q[gi] <= valid_d;
                end
            end
        end

        assign out_data  = data_q[DELAY-1];
        assign out_valid = valid_q[DELAY-1];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers one tile of column vectors, then streams it into the array edge
// with lane i skewed by i cycles so operands meet their partners in the PEs.
module systolic_feeder
    import mat_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N     = DEF_N,
    parameter int unsigned K     = DEF_K
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               in_last,
    output logic [N*WIDTH-1:0] data_out,
    output logic [N-1:0]       valid_out,
    output logic               done
);

    localparam int unsigned CW = cnt_width(K, N);
    localparam int unsigned AW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] K_LAST  = CW'(K - 1);
    localparam logic [CW-1:0] N_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    feeder_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic          done_q, done_d;

    logic          accept;
    logic          issue;
    logic [AW-1:0] buf_addr;

    logic [N*WIDTH-1:0] buf_mem [K];
    logic [N*WIDTH-1:0] issue_data_q;
    logic               issue_valid_q;

    // The same counter indexes writes in LOAD, reads in STREAM and drain cycles in FLUSH.
    assign in_ready = (state_q == ST_LOAD);
    assign accept   = in_valid && in_ready && !reset;
    assign issue    = (state_q == ST_STREAM);
    assign buf_addr = cnt_q[AW-1:0];

    // Next-state logic: tile ends on in_last or when the buffer is full.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (in_last || (cnt_q == K_LAST)) begin
                        state_d = ST_STREAM;
                        len_d   = cnt_q + CNT_ONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_STREAM: begin
                if ((cnt_q + CNT_ONE) == len_q) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == N_LAST) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    // Tile buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[buf_addr] <= in_data;
        end
    end

    // Registered buffer read; zeroed outside STREAM so idle lanes stay zero downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
        end else begin
            issue_valid_q <= issue;
            issue_data_q  <= issue ? buf_mem[buf_addr] : '0;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        skew_delay_line #(
            .WIDTH (WIDTH),
            .DELAY (gi)
        ) u_skew (
            .clk       (clk),
            .reset     (reset),
            .in_data   (issue_data_q[gi*WIDTH +: WIDTH]),
            .in_valid  (issue_valid_q),
            .out_data  (data_out[gi*WIDTH +: WIDTH]),
            .out_valid (valid_out[gi])
        );
    end

    assign done = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized and directed bench for systolic_feeder with a queue-based scoreboard.
module tb_systolic_feeder;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int K     = 4;
    localparam int DW    = N * WIDTH;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] data;
    } lane_item_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [DW-1:0] data_out;
    logic [N-1:0]  valid_out;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard state, driven purely from the accepted-beat history.
    lane_item_t    exp_q [N][$];
    logic [DW-1:0] tile_acc [$];
    int            ready_from   = 0;
    int            done_cyc     = -1;
    bit            done_pending = 0;
    bit            chk_en       = 0;

    // Stimulus tables used by send_tile.
    logic [DW-1:0] tile_in [$];
    int            gap_in  [$];

    systolic_feeder #(.WIDTH(WIDTH), .N(N), .K(K)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .data_out  (data_out),
        .valid_out (valid_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and reference model, evaluated mid-cycle for the current cycle.
    always @(negedge clk) begin
        logic [WIDTH-1:0] got;
        bit               exp_v;
        bit               exp_ready;
        bit               exp_done;
        int               s;
        int               l;

        if (chk_en) begin
            exp_ready = (cyc >= ready_from);
            checks++;
            if (in_ready !== exp_ready) begin
                failures++;
                $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready);
            end

            exp_done = done_pending && (cyc == done_cyc);
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done);
            end
            if (exp_done) begin
                done_pending = 0;
                $display("tile done at cyc=%0d", cyc);
            end

            for (int i = 0; i < N; i++) begin
                got   = data_out[i*WIDTH +: WIDTH];
                exp_v = (exp_q[i].size() > 0) && (exp_q[i][0].cyc == cyc);
                checks++;
                if (valid_out[i] !== exp_v) begin
                    failures++;
                    $display("FAIL lane%0d_valid cyc=%0d got=%b exp=%b", i, cyc, valid_out[i], exp_v);
                end
                checks++;
                if (exp_v) begin
                    if (got !== exp_q[i][0].data) begin
                        failures++;
                        $display("FAIL lane%0d_data cyc=%0d got=%02h exp=%02h", i, cyc, got, exp_q[i][0].data);
                    end
                    void'(exp_q[i].pop_front());
                end else if (got !== '0) begin
                    failures++;
                    $display("FAIL lane%0d_zero cyc=%0d got=%02h exp=00", i, cyc, got);
                end
            end
        end

        if (reset === 1'b1) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
            tile_acc.delete();
            done_pending = 0;
            ready_from   = cyc + 1;
            chk_en       = 1;
        end else if (chk_en && in_valid === 1'b1 && cyc >= ready_from) begin
            tile_acc.push_back(in_data);
            if (in_last === 1'b1 || tile_acc.size() == K) begin
                l = tile_acc.size();
                s = cyc + 1;
                for (int k = 0; k < l; k++) begin
                    for (int i = 0; i < N; i++) begin
                        lane_item_t it;
                        it.cyc  = s + 1 + k + i;
                        it.data = tile_acc[k][i*WIDTH +: WIDTH];
                        exp_q[i].push_back(it);
                    end
                end
                done_cyc     = s + l + N;
                done_pending = 1;
                ready_from   = done_cyc;
                $display("tile accepted L=%0d S=%0d expect_done=%0d", l, s, done_cyc);
                tile_acc.delete();
            end
        end
    end

    // Present tile_in beat by beat; gap_in (or random gaps) inserts idle cycles before each beat.
    task automatic send_tile(input int gapmax, input bit mark_last, input bit hold);
        bit acc;
        int gaps;
        for (int b = 0; b < tile_in.size(); b++) begin
            if (gap_in.size() > b) gaps = gap_in[b];
            else gaps = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = tile_in[b];
            in_last  = (b == tile_in.size() - 1) ? mark_last : 1'b0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
            end while (!acc);
        end
        if (!hold) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        gap_in.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        in_last  = 1'b0;
        wait_cycles(3);
        reset    = 1'b0;
        in_valid = 1'b0;
        wait_cycles(2);

        // Full tile with in_last on the fourth beat.
        tile_in = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        send_tile(0, 1'b1, 1'b0);
        wait_cycles(K + N + 3);

        // Short tile, L=2.
        tile_in = '{32'h11121314, 32'h15161718};
        send_tile(0, 1'b1, 1'b0);
        wait_cycles(K + N + 3);

        // Gaps in LOAD (valid 1,0,0,1,1,1) with an implicit end at beat K-1.
        tile_in = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        gap_in  = '{0, 2, 0, 0};
        send_tile(0, 1'b0, 1'b0);
        wait_cycles(K + N + 3);

        // in_valid held high across STREAM/FLUSH into a back-to-back tile.
        tile_in = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
        send_tile(0, 1'b1, 1'b1);
        tile_in = '{32'h21222324, 32'h31323334, 32'h41424344, 32'h51525354};
        send_tile(0, 1'b1, 1'b0);
        wait_cycles(K + N + 3);

        // Reset at S+2 of a full tile, then a clean tile.
        tile_in = '{32'h61626364, 32'h71727374, 32'h81828384, 32'h91929394};
        send_tile(0, 1'b1, 1'b0);
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(K + N + 3);
        tile_in = '{32'hCAFEF00D, 32'h12345678};
        send_tile(0, 1'b1, 1'b0);
        wait_cycles(K + N + 3);

        // Random tiles: length, data, gaps, hold-through and end style all vary.
        for (int t = 0; t < 30; t++) begin
            tile_in.delete();
            len = $urandom_range(1, K);
            for (int b = 0; b < len; b++) tile_in.push_back(DW'($urandom));
            send_tile(2, (len < K) ? 1'b1 : 1'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        wait_cycles(K + N + 6);

        checks++;
        if (done_pending || exp_q[0].size() != 0 || exp_q[N-1].size() != 0) begin
            failures++;
            $display("FAIL drain got=pending_items exp=empty");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter WIDTH, default 8: element width in bits; equals the processing-element operand width.
REQ-002 Parameter N, default 4: number of array edge lanes (rows fed).
REQ-003 Parameter K, default 4: maximum tile depth (vectors per tile); K >= 1.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data/in_last valid this cycle.
REQ-007 in_ready  output  1  feeder accepts a beat this cycle.
REQ-008 in_data  input  N*WIDTH  one tile column vector; lane i = bits [i*WIDTH +: WIDTH].
REQ-009 in_last  input  1  accepted beat is the final vector of the tile.
REQ-010 data_out  output  N*WIDTH  skewed operands to array edge; lane packing as in_data.
REQ-011 valid_out  output  N  per-lane operand valid, drives PE valid inputs.
REQ-012 done  output  1  one-cycle pulse: tile fully emitted.

Function
REQ-013 States LOAD, STREAM, FLUSH; reset enters LOAD.
REQ-014 in_ready SHALL equal (state == LOAD); a beat is accepted when in_valid && in_ready.
REQ-015 LOAD: accepted beat j stored at buffer index j; length counter increments; j counts from 0.
REQ-016 LOAD -> STREAM on accepting a beat with in_last=1 or on accepting beat K-1, whichever first; tile length L = beats accepted (1..K).
REQ-017 in_last on beat K-1 and implicit end at K-1 give identical behaviour; no beat beyond K-1 is accepted in LOAD.
REQ-018 STREAM lasts exactly L cycles, issuing buffer vector k in the k-th STREAM cycle; no backpressure from the array.
REQ-019 STREAM -> FLUSH after L cycles; FLUSH lasts exactly N cycles, then -> LOAD.
REQ-020 With S = first STREAM cycle: lane i SHALL present element (vector k, lane i) with valid_out[i]=1 at cycle S+1+k+i, for k in 0..L-1.
REQ-021 data_out lane i SHALL be zero whenever valid_out[i]=0.
REQ-022 done SHALL be 1 exactly in cycle S+L+N (first cycle back in LOAD), 0 otherwise; in_ready is also 1 that cycle.
REQ-023 Data passes unmodified; no arithmetic, no width change.
REQ-024 in_valid=0 in LOAD holds state and counter indefinitely; in_data ignored when not accepted.

Reset
REQ-025 Reset values: in_ready=1 (LOAD), valid_out=0, data_out=0, done=0, length counter=0; buffer contents unspecified.
REQ-026 Reset asserted in any state SHALL, on the next edge, force LOAD, clear all skew-line valids and done; partial tile discarded, no further valid_out.
REQ-027 A beat presented in the same cycle as reset SHALL NOT be accepted.

Structure
REQ-028 Shared package mat_mult_pkg holds the feeder state enum and default WIDTH/N/K constants.
REQ-029 One sub-module skew_delay_line (params WIDTH, DELAY) implements the per-lane register delay with valid; instantiated N times with DELAY=i.
REQ-030 Outputs SHALL be registered; no combinational path from in_* to data_out/valid_out.

Verification
REQ-031 N=4,K=4: load columns 0x01020304,0x05060708,0x090A0B0C,0x0D0E0F10 (in_last on 4th) -> lane0 04,08,0C,10 at S+1..S+4; lane3 01,05,09,0D at S+4..S+7; done at S+8.
REQ-032 Short tile: in_last on beat 1 (L=2) -> STREAM 2 cycles, lane3 valid S+4..S+5 only, done at S+6.
REQ-033 in_valid gaps in LOAD (valid 1,0,0,1,1,1) -> same output stream as REQ-031; no extra beats captured.
REQ-034 in_valid held high through STREAM/FLUSH -> in_ready=0, no beats accepted until done cycle; back-to-back tile accepted starting the done cycle.
REQ-035 Reset asserted at S+2 -> next cycle valid_out=0, done never pulses, in_ready=1, following tile processes correctly.
